// File: rtl/ddrrx_pkg.sv
// Shared types and sizing helpers for the DDR receive word assembler.
// Optional DDRRX_BYTESWAP_EN (in ddr_word_rx) reverses byte order at the FIFO input.
package ddrrx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATENCY = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Half-samples per assembled word.
  function automatic int halves(input int wordw, input int width);
    return wordw / width;
  endfunction

  // FIFO entry carries the word plus its last-of-frame flag.
  function automatic int entry_w(input int wordw);
    return wordw + 1;
  endfunction

endpackage

// File: rtl/ddr_word_rx_sfifo.sv
// Synchronous FIFO, depth 2**LG, with full/empty flags and occupancy count.
// A pop on a full FIFO frees the slot for a same-cycle push.
module sfifo #(
  parameter int DW = 33,
  parameter int LG = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LG:0]   o_count
);

  localparam int DEPTH = 1 << LG;
  localparam logic [LG:0] DEPTH_C = (LG+1)'(DEPTH);

  logic [DW-1:0] mem_r [0:DEPTH-1];
  logic [LG-1:0] wr_ptr_r;
  logic [LG-1:0] rd_ptr_r;
  logic [LG:0]   count_r;
  logic          do_rd_s;
  logic          do_wr_s;

  assign do_rd_s = i_rd && (count_r != (LG+1)'(0));
  assign do_wr_s = i_wr && ((count_r != DEPTH_C) || do_rd_s);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + LG'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + LG'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + (LG+1)'(1);
        2'b01:   count_r <= count_r - (LG+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign o_rdata = mem_r[rd_ptr_r];
  assign o_full  = (count_r == DEPTH_C);
  assign o_empty = (count_r == (LG+1)'(0));
  assign o_count = count_r;

endmodule

// File: rtl/ddr_word_rx.sv
// DDR receive word assembler: skips latency cycles, optionally drops one half-sample,
// packs half-samples into words and queues them. DDRRX_BYTESWAP_EN reverses byte order.
module ddr_word_rx
  import ddrrx_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WORDW  = 32,
  parameter int LGFIFO = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [3:0]         i_lat,
  input  logic               i_phase,
  input  logic [7:0]         i_nwords,
  input  logic               i_en,
  input  logic [2*WIDTH-1:0] i_ddr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORDW-1:0]   o_data,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_overflow
);

  // HALVES must be at least 2 so a cycle completes at most one word.
  localparam int HALVES = halves(WORDW, WIDTH);
  localparam int HCW    = $clog2(HALVES + 1);
  localparam int EW     = entry_w(WORDW);

  state_t             state_r, state_s;
  logic [3:0]         lat_r, lat_s;
  logic               first_r, first_s;
  logic [7:0]         wcnt_r, wcnt_s;
  logic [WORDW-1:0]   sr_r, sr_s;
  logic [HCW-1:0]     hcnt_r, hcnt_s;
  logic               push_r, push_s;
  logic [WORDW-1:0]   word_r, word_s;
  logic               last_r, last_s;
  logic               overflow_r;
  logic [WIDTH-1:0]   half_s;
  logic               take_s;
  logic               stop_s;
  logic [WORDW-1:0]   fifo_word_s;
  logic [EW-1:0]      fifo_rdata_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [LGFIFO:0]    fifo_count_s;
  logic               pop_s;

  assign pop_s = !fifo_empty_s && i_ready;

  // Frame sequencing and half-sample packing.
  always_comb begin
    state_s = state_r;
    lat_s   = lat_r;
    first_s = first_r;
    wcnt_s  = wcnt_r;
    sr_s    = sr_r;
    hcnt_s  = hcnt_r;
    push_s  = 1'b0;
    word_s  = word_r;
    last_s  = last_r;
    half_s  = '0;
    take_s  = 1'b0;
    stop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          lat_s   = i_lat;
          first_s = i_phase;
          wcnt_s  = i_nwords;
          hcnt_s  = '0;
          if (i_nwords == 8'd0) begin
            state_s = IDLE;
          end else if (i_lat == 4'd0) begin
            state_s = CAPTURE;
          end else begin
            state_s = LATENCY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LATENCY: begin
        if (i_en) begin
          lat_s   = lat_r - 4'd1;
          state_s = (lat_r == 4'd1) ? CAPTURE : LATENCY;
        end else begin
          state_s = LATENCY;
        end
      end
      CAPTURE: begin
        if (i_en) begin
          first_s = 1'b0;
          // Upper half first; phase drops the very first upper half of the frame.
          for (int h = 0; h < 2; h++) begin
            half_s = (h == 0) ? i_ddr[2*WIDTH-1:WIDTH] : i_ddr[WIDTH-1:0];
            take_s = !stop_s && !((h == 0) && first_r);
            if (take_s) begin
              sr_s = {sr_s[WORDW-WIDTH-1:0], half_s};
              if (hcnt_s == HCW'(HALVES - 1)) begin
                hcnt_s = '0;
                push_s = 1'b1;
                word_s = sr_s;
                last_s = (wcnt_s == 8'd1);
                wcnt_s = wcnt_s - 8'd1;
                if (wcnt_s == 8'd0) begin
                  stop_s  = 1'b1;
                  state_s = DRAIN;
                end else begin
                  state_s = CAPTURE;
                end
              end else begin
                hcnt_s = hcnt_s + HCW'(1);
              end
            end else begin
              half_s = '0;
            end
          end
        end else begin
          state_s = CAPTURE;
        end
      end
      DRAIN: begin
        // Leave as soon as the FIFO is, or is about to be, empty with nothing pending.
        if (!push_r && (fifo_empty_s ||
                        ((fifo_count_s == (LGFIFO+1)'(1)) && pop_s))) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= IDLE;
      lat_r   <= 4'd0;
      first_r <= 1'b0;
      wcnt_r  <= 8'd0;
      sr_r    <= '0;
      hcnt_r  <= '0;
      push_r  <= 1'b0;
      word_r  <= '0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      lat_r   <= lat_s;
      first_r <= first_s;
      wcnt_r  <= wcnt_s;
      sr_r    <= sr_s;
      hcnt_r  <= hcnt_s;
      push_r  <= push_s;
      word_r  <= word_s;
      last_r  <= last_s;
    end
  end

  // Sticky overflow: cleared by an accepted start, set when a word finds no room.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      overflow_r <= 1'b0;
    end else if ((state_r == IDLE) && i_start) begin
      overflow_r <= 1'b0;
    end else if (push_r && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef DDRRX_BYTESWAP_EN
  // First received byte lands in bits [7:0].
  always_comb begin
    fifo_word_s = '0;
    for (int b = 0; b < WORDW / 8; b++) begin
      fifo_word_s[8*b +: 8] = word_r[WORDW-8-8*b +: 8];
    end
  end
`else
  assign fifo_word_s = word_r;
`endif

  sfifo #(
    .DW (EW),
    .LG (LGFIFO)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (push_r),
    .i_wdata ({last_r, fifo_word_s}),
    .i_rd    (pop_s),
    .o_rdata (fifo_rdata_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s),
    .o_count (fifo_count_s)
  );

  assign o_valid    = !fifo_empty_s;
  assign o_data     = fifo_empty_s ? '0 : fifo_rdata_s[WORDW-1:0];
  assign o_last     = fifo_empty_s ? 1'b0 : fifo_rdata_s[WORDW];
  assign o_busy     = (state_r != IDLE);
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_ddr_word_rx.sv
// Directed self-checking bench for ddr_word_rx (WIDTH=4, WORDW=32, LGFIFO=2).
module tb_ddr_word_rx;

  localparam int WIDTH  = 4;
  localparam int WORDW  = 32;
  localparam int LGFIFO = 2;

`ifdef DDRRX_BYTESWAP_EN
  localparam logic [31:0] EXP_1234 = 32'h78563412;
`else
  localparam logic [31:0] EXP_1234 = 32'h12345678;
`endif

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_start;
  logic [3:0]         i_lat;
  logic               i_phase;
  logic [7:0]         i_nwords;
  logic               i_en;
  logic [2*WIDTH-1:0] i_ddr;
  logic               o_valid;
  logic               i_ready;
  logic [WORDW-1:0]   o_data;
  logic               o_last;
  logic               o_busy;
  logic               o_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ddr_word_rx #(.WIDTH(WIDTH), .WORDW(WORDW), .LGFIFO(LGFIFO)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_lat      (i_lat),
    .i_phase    (i_phase),
    .i_nwords   (i_nwords),
    .i_en       (i_en),
    .i_ddr      (i_ddr),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic data(input logic [7:0] b);
    i_en  = 1'b1;
    i_ddr = b;
    tick();
  endtask

  task automatic start(input logic [3:0] lat, input logic ph, input logic [7:0] nw);
    i_start  = 1'b1;
    i_lat    = lat;
    i_phase  = ph;
    i_nwords = nw;
    i_en     = 1'b1;
    i_ddr    = 8'hFF;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic pop();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_lat = 4'd0; i_phase = 1'b0;
    i_nwords = 8'd0; i_en = 1'b0; i_ddr = 8'h00; i_ready = 1'b0;
    tick(); tick();
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_ovf", o_overflow, 0);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_last", o_last, 0);
    i_reset = 1'b0;
    tick();

    // Case 1: phase 0, latency 2, one word.
    start(4'd2, 1'b0, 8'd1);
    check_eq("c1_busy_lat", o_busy, 1);
    tick(); tick();
    data(8'h12); data(8'h34); data(8'h56); data(8'h78);
    check_eq("c1_valid_early", o_valid, 0);
    tick();
    check_eq("c1_valid", o_valid, 1);
    check_eq("c1_data", o_data, EXP_1234);
    check_eq("c1_last", o_last, 1);
    check_eq("c1_busy_drain", o_busy, 1);
    pop();
    check_eq("c1_valid_pop", o_valid, 0);
    check_eq("c1_busy_pop", o_busy, 0);

    // Case 2: phase 1, latency 0, first upper and trailing lower halves discarded.
    start(4'd0, 1'b1, 8'd1);
    data(8'hA1); data(8'h23); data(8'h45); data(8'h67); data(8'h8B);
    check_eq("c2_valid_early", o_valid, 0);
    tick();
    check_eq("c2_data", o_data, EXP_1234);
    check_eq("c2_last", o_last, 1);
    pop();
    check_eq("c2_busy_pop", o_busy, 0);

    // Case 3: FIFO never drained, six words into four slots.
    start(4'd0, 1'b0, 8'd6);
    for (int w = 1; w <= 6; w++) begin
      for (int c = 0; c < 4; c++) begin
        data(8'hA0 + 8'(w));
      end
    end
    tick(); tick();
    check_eq("c3_valid", o_valid, 1);
    check_eq("c3_ovf", o_overflow, 1);
    check_eq("c3_busy", o_busy, 1);
    // Start while busy is ignored; overflow must stay set.
    start(4'd0, 1'b0, 8'd1);
    check_eq("c3_start_ignored_busy", o_busy, 1);
    check_eq("c3_start_ignored_ovf", o_overflow, 1);
    for (int w = 1; w <= 4; w++) begin
      check_eq("c3_word", o_data, {4{8'hA0 + 8'(w)}});
      check_eq("c3_last", o_last, 0);
      pop();
    end
    check_eq("c3_empty", o_valid, 0);
    check_eq("c3_idle", o_busy, 0);
    start(4'd0, 1'b0, 8'd0);
    check_eq("c3_ovf_clear", o_overflow, 0);
    check_eq("c3_empty_frame_idle", o_busy, 0);

    // Case 4: three stalled cycles mid-word.
    start(4'd0, 1'b0, 8'd1);
    data(8'h12); data(8'h34);
    i_en = 1'b0; i_ddr = 8'hFF;
    tick(); tick(); tick();
    data(8'h56); data(8'h78);
    check_eq("c4_valid_early", o_valid, 0);
    tick();
    check_eq("c4_valid", o_valid, 1);
    check_eq("c4_data", o_data, EXP_1234);
    pop();

    // Case 5: reset after two data cycles, then a clean frame.
    start(4'd0, 1'b0, 8'd1);
    data(8'h9A); data(8'hBC);
    i_reset = 1'b1;
    tick();
    check_eq("c5_rst_busy", o_busy, 0);
    check_eq("c5_rst_valid", o_valid, 0);
    check_eq("c5_rst_data", o_data, 0);
    i_reset = 1'b0;
    data(8'hDE); data(8'hF0); tick();
    check_eq("c5_no_word", o_valid, 0);
    start(4'd0, 1'b0, 8'd1);
    data(8'h12); data(8'h34); data(8'h56); data(8'h78);
    tick();
    check_eq("c5_data", o_data, EXP_1234);
    check_eq("c5_last", o_last, 1);
    pop();
    check_eq("c5_idle", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_word_rx.md
# ddr_word_rx

Receive-side word assembler for the DDR pin interface on the iCE40. Consumes the per-cycle pair of half-period samples from the DDR I/O primitive wrapper, skips a programmable number of latency cycles, and optionally drops one half-sample to realign the stream. It packs the remaining half-samples into full words and hands them to the bus side through a small FIFO with a valid/ready handshake. It is the read-direction counterpart to the DDR word transmitter, and sits between the pin wrapper and the flash/RAM controller logic.

## Interface
- WIDTH, 4: pins per DDR lane; i_ddr carries 2*WIDTH bits per cycle
- WORDW, 32: output word width; must be a multiple of WIDTH; HALVES = WORDW/WIDTH
- LGFIFO, 2: log2 FIFO depth (default 4 words)
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  frame start strobe; honoured only in IDLE
- i_lat  in  4  latency (dummy) cycles to discard after start
- i_phase  in  1  1: discard the first (upper) half-sample of the first data cycle
- i_nwords  in  8  words in frame; 0 = empty frame
- i_en  in  1  sample-valid qualifier; low cycles are ignored (stall)
- i_ddr  in  2*WIDTH  upper half = first (rising) half-sample, lower half = second
- o_valid  out  1  FIFO head valid
- i_ready  in  1  consumer accepts head when o_valid && i_ready
- o_data  out  WORDW  assembled word
- o_last  out  1  head is final word of its frame
- o_busy  out  1  frame in progress (not IDLE)
- o_overflow  out  1  sticky: a word completed while FIFO full and was dropped

## Operation
- Reset: state IDLE; FIFO flushed; o_valid, o_last, o_busy, o_overflow = 0; o_data = 0; shift/count registers cleared.
- States: IDLE, LATENCY, CAPTURE, DRAIN.
- IDLE: on i_start, latch i_lat, i_phase, i_nwords; clear o_overflow. If i_nwords==0 -> stay IDLE. Else if i_lat==0 -> CAPTURE, else -> LATENCY.
- LATENCY: decrement counter on each i_en-high cycle; at reaching 0 -> CAPTURE. i_ddr ignored.
- CAPTURE: each i_en-high cycle appends two half-samples (upper first), except that when phase=1 the first cycle's upper half is discarded. Word completes when HALVES halves are accumulated; a leftover half (odd alignment) carries into the next word. First half-sample lands in the MSBs.
- Completed word is pushed to FIFO with last flag on the i_nwords-th word; after last word -> DRAIN. Halves beyond the last word are discarded.
- FIFO full at completion: word dropped, o_overflow set, word still counts toward i_nwords.
- DRAIN: -> IDLE when FIFO empty. o_busy high in LATENCY, CAPTURE, DRAIN.
- i_start outside IDLE ignored. i_reset mid-frame aborts immediately with reset values; no partial word emitted.
- Simultaneous push and pop on a full FIFO: pop first, push accepted, no overflow.

## Timing
- Word completes from i_ddr registered at edge N -> written to FIFO at edge N+1 -> o_valid high after edge N+1 (empty FIFO).
- Data cycle: first i_ddr consumed is the cycle after the i_start edge plus i_lat i_en-high cycles.
- Throughput: one word per HALVES/2 i_en cycles; FIFO output holds steady while o_valid && !i_ready.

## Configuration
- DDRRX_BYTESWAP_EN defined: o_data byte order reversed at FIFO input (first byte received in bits [7:0]); requires WORDW multiple of 8.
- Undefined: first half-sample in MSBs, no swap.

## Structure
- Package ddrrx_pkg: state enum (IDLE, LATENCY, CAPTURE, DRAIN); HALVES computation; FIFO entry width (WORDW+1 for last flag).
- Sub-module: sfifo (synchronous FIFO, depth 2^LGFIFO, WORDW+1 wide, full/empty flags).

## Test plan
- WIDTH=4, phase 0, lat 2, nwords 1, data cycles 8'h12,8'h34,8'h56,8'h78 -> one word 32'h12345678, o_last=1, o_busy drops when popped.
- Phase 1, lat 0, i_ddr 8'hA1,8'h23,8'h45,8'h67,8'h8B -> 32'h12345678 (A and B discarded).
- DDRRX_BYTESWAP_EN, stimulus of first case -> 32'h78563412.
- i_ready=0, nwords 6, LGFIFO 2 -> 4 words held, o_overflow=1, words 5–6 lost; next i_start clears o_overflow.
- i_en low for 3 cycles mid-word -> same word value, output delayed 3 cycles.
- i_reset after 2 data cycles -> all outputs 0 next cycle, no word emitted; following frame assembles correctly.
